// File: rtl/mc_alu_pkg.sv
// Shared definitions for the multicycle ALU: opcode map, FSM states and
// the classification of opcodes that need the iterative datapath.
package mc_alu_pkg;

   localparam logic [3:0] ALU_MOV   = 4'h0;
   localparam logic [3:0] ALU_NOT   = 4'h1;
   localparam logic [3:0] ALU_ADD   = 4'h2;
   localparam logic [3:0] ALU_SUB   = 4'h3;
   localparam logic [3:0] ALU_OR    = 4'h4;
   localparam logic [3:0] ALU_AND   = 4'h5;
   localparam logic [3:0] ALU_XOR   = 4'h6;
   localparam logic [3:0] ALU_SLT   = 4'h7;
   localparam logic [3:0] ALU_SLL   = 4'h8;
   localparam logic [3:0] ALU_SRL   = 4'h9;
   localparam logic [3:0] ALU_SRA   = 4'hA;
   localparam logic [3:0] ALU_MULLO = 4'hB;
   localparam logic [3:0] ALU_MULHI = 4'hC;
   localparam logic [3:0] ALU_DIVU  = 4'hD;
   localparam logic [3:0] ALU_REMU  = 4'hE;
   localparam logic [3:0] ALU_ZERO  = 4'hF;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ITER,
      S_FINISH
   } state_e;

   function automatic logic is_iterative(input logic [3:0] op);
      return (op == ALU_MULLO) || (op == ALU_MULHI) ||
             (op == ALU_DIVU)  || (op == ALU_REMU);
   endfunction

endpackage

// File: rtl/mc_alu_muldiv.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per
// cycle. lo/hi are the values after the step taken in the current cycle.
module mc_alu_muldiv #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         op_div,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] lo,
   output logic [W-1:0] hi,
   output logic         last
);

   localparam int CW = $clog2(W);

   logic [W-1:0]  acc_q, acc_d;
   logic [W-1:0]  q_q, q_d;
   logic [W-1:0]  b_q;
   logic          div_q;
   logic [CW-1:0] cnt_q;
   logic [W:0]    sum;
   logic [W:0]    shifted;

   // Multiply: {acc,q} holds {partial high, remaining multiplier / low bits}.
   // Divide:   acc is the partial remainder, q shifts dividend out and quotient in.
   always_comb begin
      sum     = {1'b0, acc_q} + (q_q[0] ? {1'b0, b_q} : '0);
      shifted = {acc_q, q_q[W-1]};
      acc_d   = sum[W:1];
      q_d     = {sum[0], q_q[W-1:1]};
      if (div_q) begin
         if (shifted >= {1'b0, b_q}) begin
            acc_d = shifted[W-1:0] - b_q;
            q_d   = {q_q[W-2:0], 1'b1};
         end else begin
            acc_d = shifted[W-1:0];
            q_d   = {q_q[W-2:0], 1'b0};
         end
      end
   end

   assign lo   = q_d;
   assign hi   = acc_d;
   // Asserted one step early so the final step lands in the FINISH cycle.
   assign last = (cnt_q == CW'(W - 2));

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q <= '0;
         q_q   <= '0;
         b_q   <= '0;
         div_q <= 1'b0;
         cnt_q <= '0;
      end else if (load) begin
         acc_q <= '0;
         q_q   <= a;
         b_q   <= b;
         div_q <= op_div;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         q_q   <= q_d;
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/mc_alu.sv
// Multicycle ALU: single-cycle ops complete in IDLE, mul/div run through the
// iterative datapath; result and flags are held until the next completion.
module mc_alu
   import mc_alu_pkg::*;
#(
   parameter int word_size = 32,
   parameter int SHAMT_W   = $clog2(word_size)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [3:0]           ALUSel,
   input  logic [word_size-1:0] sourceA,
   input  logic [word_size-1:0] sourceB,
   output logic [word_size-1:0] output_data,
   output logic                 zero,
   output logic                 div_by_zero,
   output logic                 busy,
   output logic                 done
);

   state_e               state_q, state_d;
   logic [word_size-1:0] res_q, res_d;
   logic [word_size-1:0] fast_res;
   logic [word_size-1:0] md_lo, md_hi;
   logic                 zero_q, zero_d;
   logic                 dbz_q, dbz_d;
   logic                 done_q, done_d;
   logic [3:0]           op_q, op_d;
   logic                 load, md_last;
   logic                 div_op, div0;
   logic [SHAMT_W-1:0]   shamt;

   assign shamt  = sourceB[SHAMT_W-1:0];
   assign div_op = (ALUSel == ALU_DIVU) || (ALUSel == ALU_REMU);
   assign div0   = div_op && (sourceB == '0);

   // Divide-by-zero results are folded in here so they take the fast path.
   always_comb begin
      fast_res = '0;
      case (ALUSel)
         ALU_MOV:  fast_res = sourceA;
         ALU_NOT:  fast_res = ~sourceA;
         ALU_ADD:  fast_res = sourceA + sourceB;
         ALU_SUB:  fast_res = sourceA - sourceB;
         ALU_OR:   fast_res = sourceA | sourceB;
         ALU_AND:  fast_res = sourceA & sourceB;
         ALU_XOR:  fast_res = sourceA ^ sourceB;
         ALU_SLT:  fast_res = {{(word_size-1){1'b0}}, $signed(sourceA) < $signed(sourceB)};
         ALU_SLL:  fast_res = sourceA << shamt;
         ALU_SRL:  fast_res = sourceA >> shamt;
         ALU_SRA:  fast_res = $unsigned($signed(sourceA) >>> shamt);
         ALU_DIVU: fast_res = '1;
         ALU_REMU: fast_res = sourceA;
         default:  fast_res = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      zero_d  = zero_q;
      dbz_d   = dbz_q;
      op_d    = op_q;
      done_d  = 1'b0;
      load    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (is_iterative(ALUSel) && !div0) begin
                  load    = 1'b1;
                  op_d    = ALUSel;
                  state_d = S_ITER;
               end else begin
                  res_d  = fast_res;
                  zero_d = (fast_res == '0);
                  dbz_d  = div0;
                  done_d = 1'b1;
               end
            end
         end
         S_ITER: begin
            if (md_last) state_d = S_FINISH;
         end
         S_FINISH: begin
            res_d   = ((op_q == ALU_MULLO) || (op_q == ALU_DIVU)) ? md_lo : md_hi;
            zero_d  = (res_d == '0);
            dbz_d   = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         res_q   <= '0;
         zero_q  <= 1'b1;
         dbz_q   <= 1'b0;
         done_q  <= 1'b0;
         op_q    <= ALU_MOV;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         dbz_q   <= dbz_d;
         done_q  <= done_d;
         op_q    <= op_d;
      end
   end

   mc_alu_muldiv #(.W(word_size)) u_muldiv (
      .clk    (clk),
      .reset  (reset),
      .load   (load),
      .op_div (div_op),
      .a      (sourceA),
      .b      (sourceB),
      .lo     (md_lo),
      .hi     (md_hi),
      .last   (md_last)
   );

   assign output_data = res_q;
   assign zero        = zero_q;
   assign div_by_zero = dbz_q;
   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;

endmodule

// File: tb/tb_mc_alu.sv
// Directed bench for mc_alu at word_size 32 and 8; expected results are
// queued when an op is issued and compared when done is observed.
module tb_mc_alu;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        s32, z32, dz32, busy32, done32;
   logic [3:0]  sel32;
   logic [31:0] a32, b32, od32;
   logic        s8, z8, dz8, busy8, done8;
   logic [3:0]  sel8;
   logic [7:0]  a8, b8, od8;

   mc_alu #(.word_size(32)) dut32 (
      .clk(clk), .reset(reset), .start(s32), .ALUSel(sel32),
      .sourceA(a32), .sourceB(b32), .output_data(od32), .zero(z32),
      .div_by_zero(dz32), .busy(busy32), .done(done32)
   );

   mc_alu #(.word_size(8)) dut8 (
      .clk(clk), .reset(reset), .start(s8), .ALUSel(sel8),
      .sourceA(a8), .sourceB(b8), .output_data(od8), .zero(z8),
      .div_by_zero(dz8), .busy(busy8), .done(done8)
   );

   typedef struct {
      logic [31:0] d;
      logic        z;
      logic        dz;
   } exp_t;

   exp_t sb[$];
   int   passed = 0;
   int   total  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic push(input logic [31:0] d, input logic z, input logic dz);
      exp_t e;
      e.d  = d;
      e.z  = z;
      e.dz = dz;
      sb.push_back(e);
   endtask

   task automatic pop_chk(input string tag, input bit w8);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, " scoreboard empty"}, 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      chk({tag, " data"}, w8 ? {24'd0, od8} : od32, e.d);
      chk({tag, " zero"}, {31'd0, w8 ? z8 : z32}, {31'd0, e.z});
      chk({tag, " dbz"},  {31'd0, w8 ? dz8 : dz32}, {31'd0, e.dz});
   endtask

   // Issue one op, wait (bounded) for done, then check latency, busy length and result.
   task automatic run_op(input string tag, input bit w8, input logic [3:0] sel,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_d, input logic ez, input logic edz,
                         input int exp_lat);
      int   lat, bcnt;
      logic dn;
      @(negedge clk);
      if (w8) begin
         s8 = 1'b1; sel8 = sel; a8 = a[7:0]; b8 = b[7:0];
      end else begin
         s32 = 1'b1; sel32 = sel; a32 = a; b32 = b;
      end
      push(exp_d, ez, edz);
      lat  = 0;
      bcnt = 0;
      do begin
         @(negedge clk);
         s8  = 1'b0;
         s32 = 1'b0;
         lat++;
         if (w8 ? busy8 : busy32) bcnt++;
         dn = w8 ? done8 : done32;
      end while (!dn && lat < 200);
      chk({tag, " latency"}, lat, exp_lat);
      chk({tag, " busy cycles"}, bcnt, exp_lat - 1);
      pop_chk(tag, w8);
   endtask

   initial begin
      int dcount;
      reset = 1'b1;
      s32 = 1'b0; sel32 = 4'h0; a32 = '0; b32 = '0;
      s8  = 1'b0; sel8  = 4'h0; a8  = '0; b8  = '0;
      repeat (2) @(negedge clk);
      chk("reset data",  od32, 32'h0);
      chk("reset zero",  {31'd0, z32}, 32'd1);
      chk("reset dbz",   {31'd0, dz32}, 32'd0);
      chk("reset busy",  {31'd0, busy32}, 32'd0);
      chk("reset done",  {31'd0, done32}, 32'd0);
      chk("reset8 data", {24'd0, od8}, 32'h0);
      reset = 1'b0;

      // Back-to-back fast ops with start held high
      @(negedge clk);
      s32 = 1'b1; sel32 = 4'h2; a32 = 32'hFFFF_FFFF; b32 = 32'h1; push(32'h0, 1'b1, 1'b0);
      @(negedge clk);
      chk("b2b add done", {31'd0, done32}, 32'd1);
      pop_chk("b2b add", 1'b0);
      sel32 = 4'h7; a32 = 32'hFFFF_FFFE; b32 = 32'h1; push(32'h1, 1'b0, 1'b0);
      @(negedge clk);
      chk("b2b slt done", {31'd0, done32}, 32'd1);
      pop_chk("b2b slt", 1'b0);
      sel32 = 4'hA; a32 = 32'h8000_0000; b32 = 32'h4; push(32'hF800_0000, 1'b0, 1'b0);
      @(negedge clk);
      chk("b2b sra done", {31'd0, done32}, 32'd1);
      pop_chk("b2b sra", 1'b0);
      s32 = 1'b0;
      @(negedge clk);
      chk("idle done low", {31'd0, done32}, 32'd0);
      chk("hold data", od32, 32'hF800_0000);

      // Reset in the middle of a multiply
      @(negedge clk);
      s32 = 1'b1; sel32 = 4'hB; a32 = 32'd7; b32 = 32'd9;
      @(negedge clk);
      s32 = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst data", od32, 32'h0);
      chk("midrst zero", {31'd0, z32}, 32'd1);
      chk("midrst busy", {31'd0, busy32}, 32'd0);
      dcount = 0;
      repeat (40) begin
         @(negedge clk);
         if (done32) dcount++;
      end
      chk("midrst no done", dcount, 0);

      // Assorted fast ops and shift-amount masking
      run_op("sub",  1'b0, 4'h3, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1);
      run_op("sll",  1'b0, 4'h8, 32'h1, 32'h3F, 32'h8000_0000, 1'b0, 1'b0, 1);
      run_op("srl",  1'b0, 4'h9, 32'h8000_0000, 32'd31, 32'h1, 1'b0, 1'b0, 1);
      run_op("not",  1'b0, 4'h1, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
      run_op("xor",  1'b0, 4'h6, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 32'h0, 1'b1, 1'b0, 1);
      run_op("opF",  1'b0, 4'hF, 32'h1234, 32'h5678, 32'h0, 1'b1, 1'b0, 1);

      // Multiply
      run_op("mullo", 1'b0, 4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 33);
      run_op("mulhi", 1'b0, 4'hC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, 33);

      // Divide, including divide by zero
      run_op("divu",    1'b0, 4'hD, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 33);
      run_op("remu",    1'b0, 4'hE, 32'd100, 32'd7, 32'd2,  1'b0, 1'b0, 33);
      run_op("divbig",  1'b0, 4'hD, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 33);
      run_op("div0",    1'b0, 4'hD, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1);
      run_op("mov clr", 1'b0, 4'h0, 32'h1234, 32'd0, 32'h1234, 1'b0, 1'b0, 1);
      run_op("rem0",    1'b0, 4'hE, 32'd0, 32'd0, 32'h0, 1'b1, 1'b1, 1);

      // start pulses during ITER and during FINISH must be ignored
      @(negedge clk);
      s32 = 1'b1; sel32 = 4'hD; a32 = 32'd100; b32 = 32'd7;
      dcount = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (done32) begin
            dcount++;
            chk("hs data at done", od32, 32'd14);
         end
         if (k == 5 || k == 32) begin
            s32 = 1'b1; sel32 = 4'h2; a32 = 32'd1; b32 = 32'd2;
         end else begin
            s32 = 1'b0;
         end
      end
      chk("hs done count", dcount, 1);
      chk("hs data held", od32, 32'd14);

      // word_size = 8
      run_op("w8 mullo", 1'b1, 4'hB, 32'h10, 32'h10, 32'h00, 1'b1, 1'b0, 9);
      run_op("w8 mulhi", 1'b1, 4'hC, 32'h10, 32'h10, 32'h01, 1'b0, 1'b0, 9);
      run_op("w8 divu",  1'b1, 4'hD, 32'hC8, 32'h0B, 32'h12, 1'b0, 1'b0, 9);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mc_alu.md
Name: mc_alu

Overview:
- Parametrised multicycle ALU for the 32-bit multicycle datapath; successor to the single-cycle combinational ALU.
- Keeps the 4-bit select encoding for move/not/add/sub/or/and/xor/slt.
- Adds shifts and iterative unsigned multiply/divide.
- A start/busy/done handshake lets the control FSM wait on long ops; the result and flags are registered and held until the next accepted op.

Parameters:
word_size, 32, operand/result width; >= 4, power of two
SHAMT_W, $clog2(word_size), shift-amount bits taken from sourceB

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
start  in  1  request; accepted only when busy=0
ALUSel  in  4  operation select, sampled on accept
sourceA  in  word_size  operand A, sampled on accept
sourceB  in  word_size  operand B, sampled on accept
output_data  out  word_size  registered result
zero  out  1  output_data == 0, registered alongside output_data
div_by_zero  out  1  set when the last op was 0xD or 0xE with B == 0
busy  out  1  high while an iterative op is in progress
done  out  1  one-cycle pulse when output_data is valid

Behaviour:
- Reset (synchronous, active-high):
  - output_data=0, zero=1, div_by_zero=0, busy=0, done=0, state=IDLE.
  - Reset mid-operation aborts the op; no done pulse is issued.
- Ops, fixed latency 1 (start sampled at cycle N, done and result at N+1):
  - 0 A; 1 ~A; 2 A+B (mod 2^word_size); 3 A-B; 4 A|B; 5 A&B; 6 A^B.
  - 7 signed A<B -> 1 else 0.
  - 8 A<<B[SHAMT_W-1:0]; 9 logical right shift; A arithmetic right shift.
  - F -> 0.
- Ops, iterative (latency word_size+1, done at N+word_size+1):
  - B = unsigned product low half; C = unsigned product high half. Shift-add, one bit per cycle.
  - D = unsigned quotient; E = unsigned remainder. Restoring division, one bit per cycle.
- Divide by zero (D/E with B==0): takes the 1-cycle path; D -> all ones, E -> A; div_by_zero=1. Every other op clears div_by_zero on completion.
- zero: valid for every op, including after div-by-zero. It is never left stale.
- FSM:
  - IDLE: start & fast op -> latch result, done=1, stay IDLE. start & iterative op -> load operands, counter=0, busy=1 -> ITER.
  - ITER: one step per cycle; counter increments; when counter == word_size-1 -> FINISH.
  - FINISH: write result, zero, div_by_zero; done=1; busy=0 -> IDLE.
- start while busy: ignored; it is not queued. start in the FINISH cycle is also ignored (busy is still 1 that cycle).
- Back-to-back fast ops: start held high in IDLE gives one result per cycle, with done high every cycle.
- Operands are captured at accept. Input changes during ITER have no effect.
- output_data, zero and div_by_zero change only on a done cycle or reset.

Decomposition:
- Shared package mc_alu_pkg:
  - ALUSel opcode localparams (ALU_MOV..ALU_REMU).
  - FSM state encoding (IDLE/ITER/FINISH).
  - is_iterative(opcode) function.
- One sub-module, mc_alu_muldiv:
  - Holds the iterative datapath: accumulator/remainder, shifting multiplier/quotient, bit counter.
  - Ports: clk, reset, load, op_div, a, b; outputs lo, hi, last.
- Top level holds the FSM, fast-op logic, result/flag registers and handshake.

Test Plan:
1. Reset mid-multiply: reset at cycle 5 of A=7,B=9 op B -> next cycle output_data=0, zero=1, busy=0; no done pulse.
2. Fast ops back-to-back, start held high (word_size=32):
   - op 2, A=0xFFFFFFFF, B=1 -> 0, zero=1.
   - op 7, A=0xFFFFFFFE, B=1 -> 1.
   - op A, A=0x80000000, B=4 -> 0xF8000000.
   - Each result appears one cycle after its start, with done high.
3. Multiply: op B and op C, A=B=0xFFFFFFFF -> lo=0x00000001, hi=0xFFFFFFFE; done exactly 33 cycles after accept; busy high for 32 cycles.
4. Divide: op D A=100,B=7 -> 14; op E -> 2. Op D A=5,B=0 -> 0xFFFFFFFF with div_by_zero=1, done 1 cycle after accept. A following op 0 clears div_by_zero.
5. Handshake: pulse start with op 2 during an active divide -> ignored. The divide result is unchanged; exactly one done pulse.
6. Parameter sweep word_size=8: op B A=0x10,B=0x10 -> lo=0x00, zero=1; op C -> 0x01; done 9 cycles after accept.
